// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icodes, status codes, register ids, the D->E payload
// and the forwarding-priority helper.
package y86_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned STAT_W = 3;
    localparam int unsigned NREGS  = 15;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ID_W-1:0]   regId_t;

    localparam regId_t RNONE = 4'hF;
    localparam regId_t RSP   = 4'h4;

    typedef enum logic [3:0] {
        HALT   = 4'h0, NOP    = 4'h1, RRMOVQ = 4'h2, IRMOVQ = 4'h3,
        RMMOVQ = 4'h4, MRMOVQ = 4'h5, OPQ    = 4'h6, JXX    = 4'h7,
        CALL   = 4'h8, RET    = 4'h9, PUSHQ  = 4'hA, POPQ   = 4'hB
    } icode_e;

    typedef enum logic [STAT_W-1:0] {
        SAOK = 3'd1, SADR = 3'd2, SINS = 3'd3, SHLT = 3'd4
    } stat_e;

    typedef struct packed {
        logic [STAT_W-1:0] stat;
        logic [3:0]        icode;
        logic [3:0]        ifun;
        word_t             valC;
        word_t             valA;
        word_t             valB;
        regId_t            dstE;
        regId_t            dstM;
        regId_t            srcA;
        regId_t            srcB;
    } eReg_t;

    localparam eReg_t E_BUBBLE = '{
        stat: SAOK, icode: NOP, ifun: 4'h0, valC: '0, valA: '0, valB: '0,
        dstE: RNONE, dstM: RNONE, srcA: RNONE, srcB: RNONE
    };

    // Youngest producer wins; within a stage the memory result beats the ALU result.
    function automatic word_t fwdSel(
        regId_t src, word_t rfVal,
        regId_t eDstE, word_t eValE,
        regId_t mDstM, word_t mValM, regId_t mDstE, word_t mValE,
        regId_t wDstM, word_t wValM, regId_t wDstE, word_t wValE);
        if (src == RNONE)      return '0;
        else if (src == eDstE) return eValE;
        else if (src == mDstM) return mValM;
        else if (src == mDstE) return mValE;
        else if (src == wDstM) return wValM;
        else if (src == wDstE) return wValE;
        else                   return rfVal;
    endfunction

endpackage

// File: rtl/y86_fd_stage_if.sv
// Signal bundle around the F/D/E slice: pipeline stimulus side (master) and stage side (slave).
interface y86_fd_stage_if;
    import y86_pkg::*;

    logic       F_stall, F_bubble, E_stall, E_bubble;
    word_t      f_predPC, F_predPC;
    logic [3:0] D_icode, D_ifun;
    regId_t     D_rA, D_rB;
    word_t      D_valC, D_valP;
    logic [2:0] D_stat;
    regId_t     e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    word_t      e_valE, M_valE, m_valM, W_valE, W_valM;
    regId_t     d_srcA, d_srcB;
    logic [2:0] E_stat;
    logic [3:0] E_icode, E_ifun;
    word_t      E_valC, E_valA, E_valB;
    regId_t     E_dstE, E_dstM, E_srcA, E_srcB;

    modport master (
        output F_stall, F_bubble, E_stall, E_bubble, f_predPC,
               D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, D_stat,
               e_dstE, e_valE, M_dstE, M_dstM, M_valE, m_valM,
               W_dstE, W_dstM, W_valE, W_valM,
        input  F_predPC, d_srcA, d_srcB, E_stat, E_icode, E_ifun,
               E_valC, E_valA, E_valB, E_dstE, E_dstM, E_srcA, E_srcB
    );

    modport slave (
        input  F_stall, F_bubble, E_stall, E_bubble, f_predPC,
               D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, D_stat,
               e_dstE, e_valE, M_dstE, M_dstM, M_valE, m_valM,
               W_dstE, W_dstM, W_valE, W_valM,
        output F_predPC, d_srcA, d_srcB, E_stat, E_icode, E_ifun,
               E_valC, E_valA, E_valB, E_dstE, E_dstM, E_srcA, E_srcB
    );
endinterface

// File: rtl/y86_regfile.sv
// 15x64 register file: two asynchronous read ports, two write ports, M port wins on collision.
module y86_regfile
    import y86_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_n_i,
    input  regId_t rdIdA,
    input  regId_t rdIdB,
    output word_t  rdDataA_c,
    output word_t  rdDataB_c,
    input  regId_t wrIdE,
    input  word_t  wrDataE,
    input  regId_t wrIdM,
    input  word_t  wrDataM
);

    word_t regs [NREGS];

    // The M write is issued last so it overrides an E write to the same register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
        end else begin
            if (wrIdE != RNONE) regs[wrIdE] <= wrDataE;
            if (wrIdM != RNONE) regs[wrIdM] <= wrDataM;
        end
    end

    assign rdDataA_c = (rdIdA == RNONE) ? '0 : regs[rdIdA];
    assign rdDataB_c = (rdIdB == RNONE) ? '0 : regs[rdIdB];

endmodule

// File: rtl/y86_fd_stage.sv
// Y86-64 F predicted-PC register, decode (register ids, forwarding) and D->E pipeline register.
module y86_fd_stage
    import y86_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       F_stall_i,
    input  logic       F_bubble_i,
    input  word_t      f_predPC_i,
    output word_t      F_predPC_o,
    input  logic [3:0] D_icode_i,
    input  logic [3:0] D_ifun_i,
    input  regId_t     D_rA_i,
    input  regId_t     D_rB_i,
    input  word_t      D_valC_i,
    input  word_t      D_valP_i,
    input  logic [2:0] D_stat_i,
    input  regId_t     e_dstE_i,
    input  word_t      e_valE_i,
    input  regId_t     M_dstE_i,
    input  regId_t     M_dstM_i,
    input  word_t      M_valE_i,
    input  word_t      m_valM_i,
    input  regId_t     W_dstE_i,
    input  regId_t     W_dstM_i,
    input  word_t      W_valE_i,
    input  word_t      W_valM_i,
    input  logic       E_stall_i,
    input  logic       E_bubble_i,
    output regId_t     d_srcA_o,
    output regId_t     d_srcB_o,
    output logic [2:0] E_stat_o,
    output logic [3:0] E_icode_o,
    output logic [3:0] E_ifun_o,
    output word_t      E_valC_o,
    output word_t      E_valA_o,
    output word_t      E_valB_o,
    output regId_t     E_dstE_o,
    output regId_t     E_dstM_o,
    output regId_t     E_srcA_o,
    output regId_t     E_srcB_o
);

    regId_t dSrcA, dSrcB, dDstE, dDstM;
    word_t  rfA, rfB, dValA, dValB;
    word_t  fPc;
    eReg_t  eReg, eNext;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)        fPc <= '0;
        else if (F_bubble_i) fPc <= '0;
        else if (!F_stall_i) fPc <= f_predPC_i;
    end

    // Register-id generation by instruction class; unknown icodes touch nothing.
    always_comb begin
        dSrcA = RNONE;
        dSrcB = RNONE;
        dDstE = RNONE;
        dDstM = RNONE;
        case (D_icode_i)
            RRMOVQ: begin dSrcA = D_rA_i; dDstE = D_rB_i; end
            IRMOVQ: dDstE = D_rB_i;
            RMMOVQ: begin dSrcA = D_rA_i; dSrcB = D_rB_i; end
            MRMOVQ: begin dSrcB = D_rB_i; dDstM = D_rA_i; end
            OPQ:    begin dSrcA = D_rA_i; dSrcB = D_rB_i; dDstE = D_rB_i; end
            CALL:   begin dSrcB = RSP; dDstE = RSP; end
            RET:    begin dSrcA = RSP; dSrcB = RSP; dDstE = RSP; end
            PUSHQ:  begin dSrcA = D_rA_i; dSrcB = RSP; dDstE = RSP; end
            POPQ:   begin dSrcA = RSP; dSrcB = RSP; dDstE = RSP; dDstM = D_rA_i; end
            default: ;
        endcase
    end

    y86_regfile uRegfile (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .rdIdA     (dSrcA),
        .rdIdB     (dSrcB),
        .rdDataA_c (rfA),
        .rdDataB_c (rfB),
        .wrIdE     (W_dstE_i),
        .wrDataE   (W_valE_i),
        .wrIdM     (W_dstM_i),
        .wrDataM   (W_valM_i)
    );

    // CALL/JXX carry valP down the pipe in valA instead of a register value.
    always_comb begin
        dValA = fwdSel(dSrcA, rfA, e_dstE_i, e_valE_i, M_dstM_i, m_valM_i, M_dstE_i, M_valE_i,
                       W_dstM_i, W_valM_i, W_dstE_i, W_valE_i);
        if (D_icode_i == CALL || D_icode_i == JXX) dValA = D_valP_i;
        dValB = fwdSel(dSrcB, rfB, e_dstE_i, e_valE_i, M_dstM_i, m_valM_i, M_dstE_i, M_valE_i,
                       W_dstM_i, W_valM_i, W_dstE_i, W_valE_i);
    end

    always_comb begin
        eNext       = E_BUBBLE;
        eNext.stat  = D_stat_i;
        eNext.icode = D_icode_i;
        eNext.ifun  = D_ifun_i;
        eNext.valC  = D_valC_i;
        eNext.valA  = dValA;
        eNext.valB  = dValB;
        eNext.dstE  = dDstE;
        eNext.dstM  = dDstM;
        eNext.srcA  = dSrcA;
        eNext.srcB  = dSrcB;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)        eReg <= E_BUBBLE;
        else if (E_bubble_i) eReg <= E_BUBBLE;
        else if (!E_stall_i) eReg <= eNext;
    end

    assign F_predPC_o = fPc;
    assign d_srcA_o   = dSrcA;
    assign d_srcB_o   = dSrcB;
    assign E_stat_o   = eReg.stat;
    assign E_icode_o  = eReg.icode;
    assign E_ifun_o   = eReg.ifun;
    assign E_valC_o   = eReg.valC;
    assign E_valA_o   = eReg.valA;
    assign E_valB_o   = eReg.valB;
    assign E_dstE_o   = eReg.dstE;
    assign E_dstM_o   = eReg.dstM;
    assign E_srcA_o   = eReg.srcA;
    assign E_srcB_o   = eReg.srcB;

endmodule

// File: tb/tb_y86_fd_stage.sv
// Directed bench for y86_fd_stage: expected E-register contents are queued per clock edge
// and a monitor compares them against the DUT one step after each rising edge.
module tb_y86_fd_stage;
    import y86_pkg::*;

    typedef struct {
        int    cyc;
        string name;
        eReg_t e;
        word_t pc;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    int    cyc = 0;
    int    nChecks = 0;
    int    nFails = 0;
    exp_t  q[$];
    eReg_t jxxExp;

    y86_fd_stage_if fdIf ();

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    y86_fd_stage dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .F_stall_i(fdIf.F_stall), .F_bubble_i(fdIf.F_bubble),
        .f_predPC_i(fdIf.f_predPC), .F_predPC_o(fdIf.F_predPC),
        .D_icode_i(fdIf.D_icode), .D_ifun_i(fdIf.D_ifun), .D_rA_i(fdIf.D_rA), .D_rB_i(fdIf.D_rB),
        .D_valC_i(fdIf.D_valC), .D_valP_i(fdIf.D_valP), .D_stat_i(fdIf.D_stat),
        .e_dstE_i(fdIf.e_dstE), .e_valE_i(fdIf.e_valE),
        .M_dstE_i(fdIf.M_dstE), .M_dstM_i(fdIf.M_dstM), .M_valE_i(fdIf.M_valE), .m_valM_i(fdIf.m_valM),
        .W_dstE_i(fdIf.W_dstE), .W_dstM_i(fdIf.W_dstM), .W_valE_i(fdIf.W_valE), .W_valM_i(fdIf.W_valM),
        .E_stall_i(fdIf.E_stall), .E_bubble_i(fdIf.E_bubble),
        .d_srcA_o(fdIf.d_srcA), .d_srcB_o(fdIf.d_srcB),
        .E_stat_o(fdIf.E_stat), .E_icode_o(fdIf.E_icode), .E_ifun_o(fdIf.E_ifun),
        .E_valC_o(fdIf.E_valC), .E_valA_o(fdIf.E_valA), .E_valB_o(fdIf.E_valB),
        .E_dstE_o(fdIf.E_dstE), .E_dstM_o(fdIf.E_dstM), .E_srcA_o(fdIf.E_srcA), .E_srcB_o(fdIf.E_srcB)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic eReg_t mkE(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] ifn,
                                  input word_t vc, input word_t va, input word_t vb,
                                  input regId_t de, input regId_t dm, input regId_t sa, input regId_t sb);
        eReg_t e;
        e.stat = st; e.icode = ic; e.ifun = ifn; e.valC = vc; e.valA = va; e.valB = vb;
        e.dstE = de; e.dstM = dm; e.srcA = sa; e.srcB = sb;
        return e;
    endfunction

    task automatic setIdle();
        fdIf.F_stall = 1'b0; fdIf.F_bubble = 1'b0; fdIf.E_stall = 1'b0; fdIf.E_bubble = 1'b0;
        fdIf.D_icode = NOP; fdIf.D_ifun = 4'h0; fdIf.D_rA = RNONE; fdIf.D_rB = RNONE;
        fdIf.D_valC = '0; fdIf.D_valP = '0; fdIf.D_stat = SAOK;
        fdIf.e_dstE = RNONE; fdIf.M_dstE = RNONE; fdIf.M_dstM = RNONE;
        fdIf.W_dstE = RNONE; fdIf.W_dstM = RNONE;
        fdIf.e_valE = '0; fdIf.M_valE = '0; fdIf.m_valM = '0; fdIf.W_valE = '0; fdIf.W_valM = '0;
    endtask

    task automatic randInputs();
        fdIf.f_predPC = {$urandom, $urandom} | 64'h1;
        fdIf.D_icode = 4'($urandom); fdIf.D_ifun = 4'($urandom);
        fdIf.D_rA = 4'($urandom); fdIf.D_rB = 4'($urandom);
        fdIf.D_valC = {$urandom, $urandom}; fdIf.D_valP = {$urandom, $urandom};
        fdIf.D_stat = 3'($urandom);
        fdIf.e_dstE = 4'($urandom); fdIf.M_dstE = 4'($urandom); fdIf.M_dstM = 4'($urandom);
        fdIf.W_dstE = 4'($urandom); fdIf.W_dstM = 4'($urandom);
        fdIf.e_valE = {$urandom, $urandom}; fdIf.M_valE = {$urandom, $urandom};
        fdIf.m_valM = {$urandom, $urandom}; fdIf.W_valE = {$urandom, $urandom};
        fdIf.W_valM = {$urandom, $urandom};
        fdIf.F_stall = 1'b0; fdIf.F_bubble = 1'b0; fdIf.E_stall = 1'b0; fdIf.E_bubble = 1'b0;
    endtask

    // Queue the expectation for the coming rising edge, then let that edge happen.
    task automatic step(input string name, input eReg_t e, input word_t pc);
        exp_t x;
        x.cyc = cyc + 1; x.name = name; x.e = e; x.pc = pc;
        q.push_back(x);
        @(negedge clk);
    endtask

    // Monitor: compare every expectation that falls due on this edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                exp_t x;
                x = q.pop_front();
                chk({x.name, ".predPC"}, fdIf.F_predPC, x.pc);
                chk({x.name, ".stat"},  64'(fdIf.E_stat),  64'(x.e.stat));
                chk({x.name, ".icode"}, 64'(fdIf.E_icode), 64'(x.e.icode));
                chk({x.name, ".ifun"},  64'(fdIf.E_ifun),  64'(x.e.ifun));
                chk({x.name, ".valC"},  fdIf.E_valC, x.e.valC);
                chk({x.name, ".valA"},  fdIf.E_valA, x.e.valA);
                chk({x.name, ".valB"},  fdIf.E_valB, x.e.valB);
                chk({x.name, ".dstE"},  64'(fdIf.E_dstE), 64'(x.e.dstE));
                chk({x.name, ".dstM"},  64'(fdIf.E_dstM), 64'(x.e.dstM));
                chk({x.name, ".srcA"},  64'(fdIf.E_srcA), 64'(x.e.srcA));
                chk({x.name, ".srcB"},  64'(fdIf.E_srcB), 64'(x.e.srcB));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        setIdle();
        fdIf.f_predPC = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Random traffic, then an asynchronous reset in the middle of the low phase.
        repeat (3) begin
            randInputs();
            @(negedge clk);
        end
        randInputs();
        #2 rst_n = 1'b0;
        #1;
        chk("rst.predPC", fdIf.F_predPC, 64'h0);
        chk("rst.icode", 64'(fdIf.E_icode), 64'(NOP));
        chk("rst.dstE", 64'(fdIf.E_dstE), 64'(RNONE));
        chk("rst.stat", 64'(fdIf.E_stat), 64'(SAOK));
        chk("rst.valA", fdIf.E_valA, 64'h0);
        @(negedge clk);
        setIdle();
        rst_n = 1'b1;

        // Regfile write then read back through decode.
        fdIf.W_dstE = 4'h3; fdIf.W_valE = 64'h55; fdIf.f_predPC = 64'h10;
        step("wr_r3", E_BUBBLE, 64'h10);
        setIdle();
        fdIf.D_icode = OPQ; fdIf.D_ifun = 4'h1; fdIf.D_rA = 4'h3; fdIf.D_rB = 4'h3; fdIf.f_predPC = 64'h20;
        #1;
        chk("opq.d_srcA", 64'(fdIf.d_srcA), 64'h3);
        chk("opq.d_srcB", 64'(fdIf.d_srcB), 64'h3);
        step("opq", mkE(SAOK, OPQ, 4'h1, 0, 64'h55, 64'h55, 4'h3, RNONE, 4'h3, 4'h3), 64'h20);

        // Forwarding priority on r2.
        setIdle();
        fdIf.D_icode = RRMOVQ; fdIf.D_rA = 4'h2; fdIf.D_rB = 4'h5; fdIf.f_predPC = 64'h30;
        fdIf.e_dstE = 4'h2; fdIf.e_valE = 64'h11;
        fdIf.M_dstE = 4'h2; fdIf.M_valE = 64'h22;
        fdIf.W_dstE = 4'h2; fdIf.W_valE = 64'h33;
        step("fwd_e", mkE(SAOK, RRMOVQ, 0, 0, 64'h11, 0, 4'h5, RNONE, 4'h2, RNONE), 64'h30);
        fdIf.e_dstE = RNONE; fdIf.f_predPC = 64'h40;
        step("fwd_mE", mkE(SAOK, RRMOVQ, 0, 0, 64'h22, 0, 4'h5, RNONE, 4'h2, RNONE), 64'h40);
        fdIf.M_dstM = 4'h2; fdIf.m_valM = 64'h44; fdIf.f_predPC = 64'h50;
        step("fwd_mM", mkE(SAOK, RRMOVQ, 0, 0, 64'h44, 0, 4'h5, RNONE, 4'h2, RNONE), 64'h50);
        fdIf.M_dstM = RNONE; fdIf.M_dstE = RNONE;
        fdIf.W_dstM = 4'h2; fdIf.W_valM = 64'h66; fdIf.f_predPC = 64'h60;
        step("fwd_wM", mkE(SAOK, RRMOVQ, 0, 0, 64'h66, 0, 4'h5, RNONE, 4'h2, RNONE), 64'h60);
        fdIf.W_dstM = RNONE; fdIf.W_dstE = RNONE; fdIf.f_predPC = 64'h70;
        step("rf_mwins", mkE(SAOK, RRMOVQ, 0, 0, 64'h66, 0, 4'h5, RNONE, 4'h2, RNONE), 64'h70);

        // CALL uses valP and rsp; POPQ with both W ports on rsp.
        setIdle();
        fdIf.W_dstE = RSP; fdIf.W_valE = 64'h200; fdIf.f_predPC = 64'h80;
        step("wr_rsp", E_BUBBLE, 64'h80);
        setIdle();
        fdIf.D_icode = CALL; fdIf.D_valC = 64'h3000; fdIf.D_valP = 64'h1000; fdIf.f_predPC = 64'h90;
        #1;
        chk("call.d_srcB", 64'(fdIf.d_srcB), 64'(RSP));
        chk("call.d_srcA", 64'(fdIf.d_srcA), 64'(RNONE));
        step("call", mkE(SAOK, CALL, 0, 64'h3000, 64'h1000, 64'h200, RSP, RNONE, RNONE, RSP), 64'h90);
        setIdle();
        fdIf.D_icode = POPQ; fdIf.D_rA = RSP; fdIf.f_predPC = 64'hA0;
        fdIf.W_dstE = RSP; fdIf.W_valE = 64'h208; fdIf.W_dstM = RSP; fdIf.W_valM = 64'hABC;
        step("popq", mkE(SAOK, POPQ, 0, 0, 64'hABC, 64'hABC, RSP, RSP, RSP, RSP), 64'hA0);
        setIdle();
        fdIf.D_icode = RRMOVQ; fdIf.D_rA = RSP; fdIf.D_rB = 4'h1; fdIf.f_predPC = 64'hB0;
        step("rsp_rd", mkE(SAOK, RRMOVQ, 0, 0, 64'hABC, 0, 4'h1, RNONE, RSP, RNONE), 64'hB0);

        // Undefined icode: no sources, RNONE never matches an RNONE forward.
        setIdle();
        fdIf.D_icode = 4'hD; fdIf.D_rA = 4'h1; fdIf.D_rB = 4'h2; fdIf.D_valP = 64'h5;
        fdIf.e_valE = 64'h77; fdIf.f_predPC = 64'hC0;
        #1;
        chk("undef.d_srcA", 64'(fdIf.d_srcA), 64'(RNONE));
        chk("undef.d_srcB", 64'(fdIf.d_srcB), 64'(RNONE));
        step("undef", mkE(SAOK, 4'hD, 0, 0, 0, 0, RNONE, RNONE, RNONE, RNONE), 64'hC0);
        setIdle();
        fdIf.D_icode = JXX; fdIf.D_ifun = 4'h3; fdIf.D_stat = SADR;
        fdIf.D_valC = 64'h7000; fdIf.D_valP = 64'h4444; fdIf.f_predPC = 64'hD0;
        jxxExp = mkE(SADR, JXX, 4'h3, 64'h7000, 64'h4444, 0, RNONE, RNONE, RNONE, RNONE);
        step("jxx", jxxExp, 64'hD0);

        // Stall holds both registers; bubble beats stall.
        setIdle();
        fdIf.D_icode = OPQ; fdIf.D_rA = 4'h3; fdIf.D_rB = 4'h3;
        fdIf.F_stall = 1'b1; fdIf.E_stall = 1'b1; fdIf.f_predPC = 64'h999;
        step("stall", jxxExp, 64'hD0);
        fdIf.f_predPC = 64'h777;
        step("stall2", jxxExp, 64'hD0);
        fdIf.F_bubble = 1'b1; fdIf.E_bubble = 1'b1;
        step("bubble", E_BUBBLE, 64'h0);
        setIdle();
        fdIf.f_predPC = 64'hE0;
        step("resume", E_BUBBLE, 64'hE0);

        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
